ram_store_queue: RTL
====================

# ram_store_queue

Parametrised store-data path for the MEM stage. It selects store data from one of NSRC register/address sources and queues {address, data} pairs in a DEPTH-entry FIFO. It drains the queue to the data RAM port over a valid/ready handshake and forwards the youngest queued store to a same-address load. It replaces the combinational store-data mux; the "no-op keeps last value" behaviour becomes an explicit registered hold value instead of a latch.

## Interface
- DATA_W, 16, data width of sources, queue entries and RAM data
- ADDR_W, 16, address width
- NSRC, 4, number of store-data sources; must be less than 2**SEL_W
- SEL_W, 3, width of the source-select field
- DEPTH, 4, queue entries; power of two and at least 2
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- st_valid  input  1  MEM stage presents a store
- st_ready  output  1  queue can accept a store (not full)
- st_addr  input  ADDR_W  store address
- st_sel  input  SEL_W  source select; values 0..NSRC-1 pick a source, any value at or above NSRC picks last_data
- src_data  input  NSRC*DATA_W  packed sources; source i is bits [i*DATA_W +: DATA_W]
- last_data  output  DATA_W  data of the most recently accepted store
- mem_valid  output  1  head entry available for RAM
- mem_ready  input  1  RAM accepts the head entry
- mem_addr  output  ADDR_W  head entry address
- mem_data  output  DATA_W  head entry data
- ld_addr  input  ADDR_W  load address to check against queued stores
- ld_hit  output  1  some queued entry matches ld_addr
- ld_data  output  DATA_W  data of the youngest matching entry
- count  output  $clog2(DEPTH)+1  number of occupied entries
- empty  output  1  count == 0
- full  output  1  count == DEPTH

## Operation
- Data select (combinational): sel_data = src_data slice st_sel when st_sel < NSRC, otherwise last_data.
- Enqueue: when st_valid && st_ready, write {st_addr, sel_data} at the write pointer. The write pointer increments modulo DEPTH and last_data <= sel_data.
- Without an accepted store, last_data holds its value. No latches anywhere.
- st_ready = !full. A store offered while full is not accepted, even if a dequeue happens in the same cycle.
- Dequeue: mem_valid = !empty. mem_addr/mem_data come from the head entry (combinational read of registered storage). When mem_valid && mem_ready, the read pointer increments modulo DEPTH.
- While mem_valid is high and mem_ready is low, mem_addr/mem_data stay stable.
- Count: +1 on enqueue only, -1 on dequeue only, unchanged when both or neither happen. Pointers carry an extra wrap bit, or count is kept explicitly; either way full and empty must never be ambiguous.
- Forwarding (combinational) searches the registered entries present at the start of the cycle:
  - ld_hit = 1 if any occupied entry's address equals ld_addr.
  - ld_data = data of the youngest such entry (closest to the write pointer); 0 when there is no hit.
  - The entry at the head during a dequeue cycle still counts.
  - The store being enqueued in the same cycle does not count.
- Reset (rst low, asynchronous):
  - count = 0, pointers = 0, last_data = 0, so empty = 1, full = 0, st_ready = 1, mem_valid = 0, ld_hit = 0, ld_data = 0.
  - Entry storage need not be cleared. A reset mid-operation discards all queued stores.

## Timing
- Enqueue to head visibility: 1 cycle. A store accepted at edge N into an empty queue gives mem_valid = 1 after edge N, with mem_addr/mem_data equal to that store.
- Dequeue takes effect at the accepting edge; the next entry (if any) is presented in the following cycle.
- Throughput: one enqueue and one dequeue per cycle sustained when 0 < count < DEPTH.
- Forwarding is zero-latency from ld_addr and combinational only. Store-to-load forwarding becomes visible 1 cycle after enqueue.
- last_data updates at the same edge as the enqueue; st_sel >= NSRC uses the pre-edge value.

## Test plan
- Reset then single store: pulse rst low; check st_ready=1, empty=1, mem_valid=0, count=0. Store addr 0x0010, sel 1, src1 = 0xBEEF with mem_ready=0 -> next cycle mem_valid=1, mem_addr=0x0010, mem_data=0xBEEF, count=1, last_data=0xBEEF.
- Fill and stall: 4 stores (addr 0x20..0x23) with mem_ready=0 -> full=1, st_ready=0, count=4. A 5th st_valid is refused, and the head stays at 0x20 throughout.
- Drain with wrap: after the fill, hold mem_ready=1 and keep enqueuing 0x24..0x27 in the same cycles -> RAM receives 0x20..0x27 in order, with no duplicates or losses across pointer wrap.
- Hold select: store with sel=2 (src2=0x1234), then a store with sel=5 -> the second entry's data is 0x1234 while src2 has changed to 0x5555.
- Forwarding: queue addr 0x40 data 0x1111, then addr 0x40 data 0x2222 -> ld_addr=0x40 gives ld_hit=1, ld_data=0x2222. ld_addr=0x41 gives ld_hit=0, ld_data=0. After both drain, ld_hit=0.
- Reset mid-operation: with 3 entries queued and mem_ready toggling, assert rst asynchronously between edges -> outputs go to reset values immediately, and no further mem_valid appears until a new store.

Source files
------------

// File: rtl/ram_store_queue.sv
`default_nettype none
// ============================================================================
// Module   : ram_store_queue
// Purpose  : MEM-stage store-data select feeding a DEPTH-entry store FIFO that
//            drains to the data RAM and forwards the youngest match to loads.
// Revision : 1.0 - initial release
// ============================================================================
module ram_store_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int NSRC   = 4,
  parameter int SEL_W  = 3,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [SEL_W-1:0]         st_sel,
  input  logic [NSRC*DATA_W-1:0]   src_data,
  output logic [DATA_W-1:0]        last_data,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [DATA_W-1:0]        ld_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [ADDR_W-1:0]  r_addr_mem [DEPTH];
  logic [DATA_W-1:0]  r_data_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [DATA_W-1:0]  r_last;

  logic [DATA_W-1:0]  w_sel_data;
  logic               w_enq;
  logic               w_deq;
  logic               w_ld_hit;
  logic [DATA_W-1:0]  w_ld_data;
  logic [c_PTR_W-1:0] w_fwd_idx;

  assign full      = (r_count == c_CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign st_ready  = !full;
  assign mem_valid = !empty;
  assign mem_addr  = r_addr_mem[r_rd_ptr];
  assign mem_data  = r_data_mem[r_rd_ptr];
  assign count     = r_count;
  assign last_data = r_last;
  assign ld_hit    = w_ld_hit;
  assign ld_data   = w_ld_data;

  assign w_enq = st_valid && st_ready;
  assign w_deq = mem_valid && mem_ready;

  // Out-of-range selects reuse the previously stored value (the "no-op" source).
  always_comb begin
    w_sel_data = r_last;
    for (int i = 0; i < NSRC; i++) begin
      if (st_sel == SEL_W'(i)) begin
        w_sel_data = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    w_ld_hit  = 1'b0;
    w_ld_data = '0;
    w_fwd_idx = r_rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      w_fwd_idx = r_rd_ptr + c_PTR_W'(k);
      if ((c_CNT_W'(k) < r_count) && (r_addr_mem[w_fwd_idx] == ld_addr)) begin
        w_ld_hit  = 1'b1;
        w_ld_data = r_data_mem[w_fwd_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        r_last   <= w_sel_data;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage is left uncleared; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr_mem[r_wr_ptr] <= st_addr;
      r_data_mem[r_wr_ptr] <= w_sel_data;
    end
  end

endmodule
`default_nettype wire
